// File: rtl/morse_pkg.sv
// Shared definitions for the Morse letter decoder.
//   state_t      : decoder FSM states (IDLE / COLLECT / COMMIT)
//   BLANK        : active-low glyph with every segment off (word space)
//   UNKNOWN      : active-low glyph with only segment g lit
//   glyph_t      : lookup result (known flag + active-low segments a..g)
//   lookup_glyph : maps {length, code} to a glyph. The code holds the first
//                  symbol in its most significant used bit; dot=0, dash=1.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMMIT
  } state_t;

  localparam logic [6:0] BLANK   = 7'h7F;
  localparam logic [6:0] UNKNOWN = 7'b1111110;

  typedef struct packed {
    logic       known;
    logic [6:0] seg;
  } glyph_t;

  // Table entries are written as lit segments (abcdefg, 1 = on) because that
  // reads like the glyph; the panel itself is driven active-low.
  function automatic glyph_t lit(input logic [6:0] abcdefg);
    glyph_t g;
    g.known = 1'b1;
    g.seg   = ~abcdefg;
    return g;
  endfunction

  // K, M, V, W and X have no legible seven-segment form and fall to default.
  function automatic glyph_t lookup_glyph(input logic [2:0] len, input logic [5:0] code);
    glyph_t g;
    g.known = 1'b0;
    g.seg   = UNKNOWN;
    case ({len, code})
      {3'd1, 6'b000000}: g = lit(7'b1001111); // E  .
      {3'd1, 6'b000001}: g = lit(7'b0001111); // t  -
      {3'd2, 6'b000001}: g = lit(7'b1110111); // A  .-
      {3'd2, 6'b000000}: g = lit(7'b0110000); // I  ..
      {3'd2, 6'b000010}: g = lit(7'b0010101); // n  -.
      {3'd3, 6'b000100}: g = lit(7'b0111101); // d  -..
      {3'd3, 6'b000110}: g = lit(7'b1011110); // G  --.
      {3'd3, 6'b000111}: g = lit(7'b0011101); // o  ---
      {3'd3, 6'b000010}: g = lit(7'b0000101); // r  .-.
      {3'd3, 6'b000000}: g = lit(7'b1011011); // S  ...
      {3'd3, 6'b000001}: g = lit(7'b0111110); // U  ..-
      {3'd4, 6'b001000}: g = lit(7'b0011111); // b  -...
      {3'd4, 6'b001010}: g = lit(7'b1001110); // C  -.-.
      {3'd4, 6'b000010}: g = lit(7'b1000111); // F  ..-.
      {3'd4, 6'b000000}: g = lit(7'b0110111); // H  ....
      {3'd4, 6'b000111}: g = lit(7'b0111000); // J  .---
      {3'd4, 6'b000100}: g = lit(7'b0001110); // L  .-..
      {3'd4, 6'b000110}: g = lit(7'b1100111); // P  .--.
      {3'd4, 6'b001101}: g = lit(7'b1110011); // q  --.-
      {3'd4, 6'b001011}: g = lit(7'b0111011); // y  -.--
      {3'd4, 6'b001100}: g = lit(7'b1101101); // Z  --..
      {3'd5, 6'b011111}: g = lit(7'b1111110); // 0
      {3'd5, 6'b001111}: g = lit(7'b0110000); // 1
      {3'd5, 6'b000111}: g = lit(7'b1101101); // 2
      {3'd5, 6'b000011}: g = lit(7'b1111001); // 3
      {3'd5, 6'b000001}: g = lit(7'b0110011); // 4
      {3'd5, 6'b000000}: g = lit(7'b1011011); // 5
      {3'd5, 6'b010000}: g = lit(7'b1011111); // 6
      {3'd5, 6'b011000}: g = lit(7'b1110000); // 7
      {3'd5, 6'b011100}: g = lit(7'b1111111); // 8
      {3'd5, 6'b011110}: g = lit(7'b1111011); // 9
      default: ;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/morse_debounce.sv
// Button conditioning for one raw active-low push button.
//   clk, rst      : clock, asynchronous active-high reset
//   btn_n         : raw asynchronous button level (0 = pressed)
//   release_pulse : one-cycle pulse when the conditioned level goes 0 -> 1
// Build option MORSE_DEBOUNCE_EN: when defined, a new synchronized level is
// accepted only after DEB_CYCLES consecutive equal samples; otherwise the
// synchronized level is used directly and DEB_CYCLES has no effect.
module morse_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic release_pulse
);

  logic sync1, sync2;
  logic level, level_d;

  // Everything resets to the released level so a button held through reset
  // cannot fake a release when reset drops.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would collapse the synchronizer stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             stable;

  // cnt counts consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = stable;
`else
  logic deb_unused;
  assign deb_unused = |DEB_CYCLES;
  assign level      = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_d <= 1'b1;
    else     level_d <= level;
  end

  // Both terms are flop outputs, so the pulse is glitch-free.
  assign release_pulse = level & ~level_d;

endmodule

// File: rtl/morse_letter_decoder.sv
// Morse letter decoder with a scrolling seven-segment display buffer.
//   clk, rst       : clock, asynchronous active-high reset
//   dot_n, dash_n  : raw active-low buttons; a symbol is entered on release
//   commit         : one-cycle pulse ending the current letter (word space
//                    when no symbol is held)
//   clear          : one-cycle pulse blanking the display and the partial letter
//   ssd            : active-low segments, digit k at [7k+6:7k], bit 6=a..0=g,
//                    digit 0 is the newest letter
//   sym_len        : symbols held for the current letter
//   err            : one-cycle pulse on overflow, dot+dash together, a symbol
//                    during COMMIT, or an undisplayable/unknown letter
// Build option MORSE_DEBOUNCE_EN enables the button debouncers.
module morse_letter_decoder
  import morse_pkg::*;
#(
  parameter int MAX_SYM    = 5,
  parameter int NUM_DIGITS = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dot_n,
  input  logic                         dash_n,
  input  logic                         commit,
  input  logic                         clear,
  output logic [NUM_DIGITS*7-1:0]      ssd,
  output logic [$clog2(MAX_SYM+1)-1:0] sym_len,
  output logic                         err
);

  localparam int LEN_W = $clog2(MAX_SYM + 1);
  localparam int SSD_W = NUM_DIGITS * 7;

  state_t             state;
  logic [MAX_SYM-1:0] code;
  logic               overflow;
  logic               dot_pulse, dash_pulse;
  glyph_t             lk;
  logic [6:0]         new_glyph;
  logic               glyph_bad;

  morse_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dot (
    .clk           (clk),
    .rst           (rst),
    .btn_n         (dot_n),
    .release_pulse (dot_pulse)
  );

  morse_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dash (
    .clk           (clk),
    .rst           (rst),
    .btn_n         (dash_n),
    .release_pulse (dash_pulse)
  );

  // Glyph to write when the COMMIT state retires: empty letter is a word
  // space, an overflowed letter is forced to UNKNOWN.
  // NOTE: every output of this always_comb is assigned before any branch, so
  // no path leaves a value held and no latch is inferred.
  always_comb begin
    lk        = lookup_glyph(3'(sym_len), 6'(code));
    new_glyph = lk.seg;
    glyph_bad = ~lk.known;
    if (sym_len == '0) begin
      new_glyph = BLANK;
      glyph_bad = 1'b0;
    end else if (overflow) begin
      new_glyph = UNKNOWN;
      glyph_bad = 1'b1;
    end
  end

  // Priority is clear > commit > symbol; a commit seen together with a
  // symbol drops the symbol silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      code     <= '0;
      sym_len  <= '0;
      overflow <= 1'b0;
      err      <= 1'b0;
      ssd      <= '1;
    end else begin
      err <= 1'b0;
      if (clear) begin
        ssd      <= '1;
        code     <= '0;
        sym_len  <= '0;
        overflow <= 1'b0;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE, COLLECT: begin
            if (commit) begin
              state <= COMMIT;
            end else if (dot_pulse && dash_pulse) begin
              err <= 1'b1;
            end else if (dot_pulse || dash_pulse) begin
              if (sym_len == LEN_W'(MAX_SYM)) begin
                err      <= 1'b1;
                overflow <= 1'b1;
              end else begin
                code    <= (code << 1) | MAX_SYM'(dash_pulse);
                sym_len <= sym_len + 1'b1;
                state   <= COLLECT;
              end
            end
          end
          COMMIT: begin
            ssd      <= (ssd << 7) | SSD_W'(new_glyph);
            err      <= glyph_bad | dot_pulse | dash_pulse;
            code     <= '0;
            sym_len  <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_letter_decoder.sv
// Self-checking bench for morse_letter_decoder: directed cases followed by
// random key/commit/clear traffic compared against a string-based model.
module tb_morse_letter_decoder;

  localparam int MAX_SYM    = 5;
  localparam int NUM_DIGITS = 4;
  localparam int DEB_CYCLES = 16;
`ifdef MORSE_DEBOUNCE_EN
  localparam int LAT = DEB_CYCLES + 1;  // release-to-commit offset hitting COMMIT
`else
  localparam int LAT = 1;
`endif
  localparam int SETTLE = LAT + 6;
  localparam logic [NUM_DIGITS*7-1:0] ALL_BLANK = '1;

  logic                      clk = 1'b0;
  logic                      rst, dot_n, dash_n, commit, clear;
  logic [NUM_DIGITS*7-1:0]   ssd;
  logic [2:0]                sym_len;
  logic                      err;

  morse_letter_decoder #(
    .MAX_SYM    (MAX_SYM),
    .NUM_DIGITS (NUM_DIGITS),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dot_n   (dot_n),
    .dash_n  (dash_n),
    .commit  (commit),
    .clear   (clear),
    .ssd     (ssd),
    .sym_len (sym_len),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;
  int exp_err  = 0;

  always @(posedge clk) begin
    #1;
    if (err === 1'b1) err_seen++;
  end

  // Reference letters and their lit segments (abcdefg, 1 = on; 0 = no glyph).
  string morse_tab [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
    "---..", "----."};
  logic [6:0] lit_tab [36] = '{
    7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
    7'b1011110, 7'b0110111, 7'b0110000, 7'b0111000, 7'b0000000, 7'b0001110,
    7'b0000000, 7'b0010101, 7'b0011101, 7'b1100111, 7'b1110011, 7'b0000101,
    7'b1011011, 7'b0001111, 7'b0111110, 7'b0000000, 7'b0000000, 7'b0000000,
    7'b0111011, 7'b1101101,
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
    7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  logic [6:0] exp_dig [NUM_DIGITS];
  string      cur;
  bit         ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [NUM_DIGITS*7-1:0] exp_ssd();
    logic [NUM_DIGITS*7-1:0] v;
    for (int k = 0; k < NUM_DIGITS; k++) v[k*7 +: 7] = exp_dig[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NUM_DIGITS; k++) exp_dig[k] = 7'h7F;
    cur = "";
    ovf = 1'b0;
  endtask

  // kind: 0 = dot, 1 = dash, 2 = both released together
  task automatic model_symbol(input int kind);
    if (kind == 2) exp_err++;
    else if (cur.len() == MAX_SYM) begin
      exp_err++;
      ovf = 1'b1;
    end else cur = {cur, (kind == 1) ? "-" : "."};
  endtask

  task automatic model_commit();
    logic [6:0] g;
    bit         found;
    g = 7'b1111110;
    found = 1'b0;
    if (cur == "") begin
      g = 7'h7F;
      found = 1'b1;
    end else if (!ovf) begin
      for (int i = 0; i < 36; i++)
        if (morse_tab[i] == cur && lit_tab[i] != 7'd0) begin
          g = ~lit_tab[i];
          found = 1'b1;
        end
    end
    if (!found) exp_err++;
    for (int k = NUM_DIGITS - 1; k > 0; k--) exp_dig[k] = exp_dig[k-1];
    exp_dig[0] = g;
    cur = "";
    ovf = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_ssd"}, 64'(ssd), 64'(exp_ssd()));
    check({tag, "_len"}, 64'(sym_len), 64'(cur.len()));
    check({tag, "_err"}, 64'(err_seen), 64'(exp_err));
  endtask

  task automatic key(input int kind);
    if (kind != 1) dot_n = 1'b0;
    if (kind != 0) dash_n = 1'b0;
    tick(SETTLE);
    dot_n  = 1'b1;
    dash_n = 1'b1;
    tick(SETTLE);
    model_symbol(kind);
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    tick(4);
    model_commit();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(4);
    model_clear();
  endtask

  initial begin
    rst = 1'b1; dot_n = 1'b1; dash_n = 1'b1; commit = 1'b0; clear = 1'b0;
    model_clear();
    tick(3);
    check("reset_ssd", 64'(ssd), 64'(ALL_BLANK));
    check("reset_len", 64'(sym_len), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    rst = 1'b0;
    tick(2);

    // Single dot -> E
    key(0);
    check_state("e_sym");
    do_commit();
    check("e_digit0", 64'(ssd[6:0]), 64'(7'b0110000));
    check_state("e_commit");

    // A, then 1 pushes A into digit 1
    key(0); key(1);
    do_commit();
    check("a_digit0", 64'(ssd[6:0]), 64'(7'b0001000));
    key(0); key(1); key(1); key(1); key(1);
    do_commit();
    check("one_digit0", 64'(ssd[6:0]), 64'(7'b1001111));
    check("one_digit1", 64'(ssd[13:7]), 64'(7'b0001000));
    check_state("a_one");

    // Overflow: sixth dash is rejected with err
    for (int i = 0; i < 6; i++) key(1);
    check_state("ovf_sym6");
    do_commit();
    check("ovf_digit0", 64'(ssd[6:0]), 64'(7'b1111110));
    check_state("ovf_commit");

    // Bouncing dot release: three 3-cycle glitches then a clean release
    dot_n = 1'b0;
    tick(SETTLE);
    for (int i = 0; i < 3; i++) begin
      dot_n = 1'b1; tick(3);
      dot_n = 1'b0; tick(3);
    end
    dot_n = 1'b1;
    tick(SETTLE);
`ifdef MORSE_DEBOUNCE_EN
    model_symbol(0);
`else
    for (int i = 0; i < 4; i++) model_symbol(0);
`endif
    check_state("bounce");
    do_commit();
    check_state("bounce_commit");

    // Clear beats commit in the same cycle
    key(0); key(1);
    check_state("cc_pre");
    clear = 1'b1; commit = 1'b1;
    tick(1);
    clear = 1'b0; commit = 1'b0;
    tick(4);
    model_clear();
    check("cc_blank", 64'(ssd), 64'(ALL_BLANK));
    check_state("cc");

    // Dot release timed to land while the FSM sits in COMMIT
    key(0);
    dot_n = 1'b0;
    tick(SETTLE);
    dot_n = 1'b1;
    tick(LAT);
    commit = 1'b1;
    tick(1);
    commit = 1'b0;
    tick(SETTLE);
    model_commit();
    exp_err++;
    check_state("sym_in_commit");

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 7)       key(0);
      else if (r < 13) key(1);
      else if (r < 17) do_commit();
      else if (r < 19) key(2);
      else             do_clear();
      check_state($sformatf("rnd%0d", n));
    end

    // Asynchronous reset in the middle of a letter
    key(0);
    do_commit();
    key(0); key(1); key(0);
    check_state("pre_rst");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ssd", 64'(ssd), 64'(ALL_BLANK));
    check("arst_len", 64'(sym_len), 64'd0);
    model_clear();
    tick(2);
    rst = 1'b0;
    tick(2);
    key(1);
    do_commit();
    check("post_rst_t", 64'(ssd[6:0]), 64'(7'b1110000));
    check_state("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_letter_decoder.md
MORSE_LETTER_DECODER -- requirements
Module: morse_letter_decoder

Interface
REQ-001 SHALL have parameter MAX_SYM, default 5, meaning maximum dots/dashes per letter (range 1..6).
REQ-002 SHALL have parameter NUM_DIGITS, default 4, meaning seven-segment digits in the scrolling display buffer (range 1..8).
REQ-003 SHALL have parameter DEB_CYCLES, default 16, meaning consecutive stable clk cycles needed to accept a button level.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have ports dot_n and dash_n, input, 1 bit each: raw active-low, asynchronous buttons; a symbol is entered on release (0->1).
REQ-007 SHALL have port commit, input, 1 bit: synchronous one-cycle pulse that ends the current letter.
REQ-008 SHALL have port clear, input, 1 bit: synchronous one-cycle pulse that blanks the display and discards the partial letter.
REQ-009 SHALL have port ssd, output, NUM_DIGITS*7 bits: active-low segments; digit k at [7k+6:7k], bit 6=a ... bit 0=g; digit 0 holds the newest letter.
REQ-010 SHALL have port sym_len, output, $clog2(MAX_SYM+1) bits: symbols held for the current letter.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse on any error event in REQ-019/020/021.

Function
REQ-012 SHALL pass dot_n and dash_n through a 2-flop synchronizer, then debounce (REQ-026), then detect the release edge as a one-cycle pulse.
REQ-013 SHALL implement FSM states IDLE (sym_len=0), COLLECT (sym_len>0) and COMMIT (one cycle).
REQ-014 SHALL, on a dot pulse, shift 0 into the LSB of the code register and increment sym_len on the following clk edge; a dash pulse shifts in 1; IDLE->COLLECT on the first symbol.
REQ-015 SHALL, on commit in COLLECT, enter COMMIT, look up {sym_len, code} in the package table, shift the display buffer up one digit (top digit discarded), write the glyph into digit 0, then clear code/sym_len and return to IDLE; ssd reflects the new glyph 2 cycles after commit.
REQ-016 SHALL, on commit in IDLE, shift the buffer and insert blank 7'h7F (word space) into digit 0 with the same latency.
REQ-017 SHALL decode A–Z and 0–9; letters with no seven-segment glyph and unknown codes display 7'b1111110 (segment g only) and pulse err.
REQ-018 SHALL prioritise clear > commit > symbol when pulses coincide; the lower-priority events in that cycle are discarded.
REQ-019 SHALL discard a symbol when sym_len==MAX_SYM, pulse err and set an overflow flag that forces the next commit to show 7'b1111110.
REQ-020 SHALL ignore dot and dash pulses arriving in the same cycle and pulse err.
REQ-021 SHALL ignore symbols arriving during COMMIT and pulse err.
REQ-022 SHALL, on clear, set every digit to 7'h7F, zero code/sym_len/overflow and go to IDLE on the next edge.

Reset
REQ-023 SHALL, while rst=1, asynchronously force ssd to all ones (blank), sym_len=0, err=0, FSM=IDLE, code/overflow=0, and synchronizer/debouncer state to released (1).
REQ-024 SHALL accept no symbol until the first edge after rst deasserts; a button held through reset produces no pulse until it is pressed and released again.

Configuration
REQ-025 SHALL support macro MORSE_DEBOUNCE_EN.
REQ-026 SHALL, with MORSE_DEBOUNCE_EN defined, accept a new button level only after DEB_CYCLES consecutive equal synchronized samples; without it, the synchronized level is used directly (latency = synchronizer only) and DEB_CYCLES is unused.

Structure
REQ-027 SHALL place the FSM state enum, glyph constants (BLANK=7'h7F, UNKNOWN=7'b1111110) and the code-to-glyph lookup function in shared package morse_pkg.
REQ-028 SHALL instantiate sub-module morse_debounce (synchronizer, debouncer, release-edge pulse) once per button.

Verification
REQ-029 SHALL verify: dot release then commit -> digit0 = 7'b0110000 ("E"), sym_len=0, err=0.
REQ-030 SHALL verify: dot, dash, commit -> digit0 = 7'b0001000 ("A"); then dot, dash, dash, dash, dash, commit -> digit0 = 7'b1001111 ("1") and digit1 = "A".
REQ-031 SHALL verify: MAX_SYM=5, six dashes, commit -> err on 6th, digit0 = 7'b1111110.
REQ-032 SHALL verify: dot_n bounce of 3-cycle glitches with MORSE_DEBOUNCE_EN, DEB_CYCLES=16 -> exactly one symbol accepted.
REQ-033 SHALL verify: clear and commit in the same cycle with sym_len=2 -> all digits 7'h7F, sym_len=0, no glyph written.
REQ-034 SHALL verify: rst asserted mid-COLLECT (sym_len=3) -> ssd all ones and sym_len=0 immediately, without waiting for a clock edge.
